// File: rtl/ifu_fetch_queue_if.sv
// Bundle between the fetch queue, the instruction memory and decode.
// Handshake: decode takes the head entry on a rising clk edge where out_valid
// and out_ready are both 1; out_valid never depends on out_ready, and the
// head fields stay stable while out_valid is 1 and no pop or redirect occurs.
interface ifu_fetch_queue_if #(
  parameter int IM_AW    = 10,
  parameter int FQ_DEPTH = 4
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic             im_req;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [31:0]      out_npc;
  logic [CW-1:0]    fq_count;

  modport master (
    output im_req, im_addr, out_valid, out_instr, out_pc, out_npc, fq_count,
    input  im_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  im_req, im_addr, out_valid, out_instr, out_pc, out_npc, fq_count,
    output im_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Decoupled MIPS fetch: sequential PC generation into a 1-cycle synchronous
// instruction memory, with {pc, instr} pairs buffered in a FIFO toward decode.
module ifu_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_AW    = 10,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  ifu_fetch_queue_if.master bus,
  output logic [31:0] dbg_fpc_o,
  output logic        dbg_inflight_o
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] pc_mem    [FQ_DEPTH];
  logic [31:0] instr_mem [FQ_DEPTH];

  logic        issue;
  logic        push;
  logic        pop;
  logic        head_valid;
  logic [CW:0] occupancy;

  // The in-flight fetch reserves a slot so its response can never overflow.
  assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue      = !reset && !bus.redirect && (occupancy < (CW+1)'(FQ_DEPTH));
  assign head_valid = (count_q != '0);
  assign push       = inflight_q && !bus.redirect;
  assign pop        = head_valid && bus.out_ready && !bus.redirect;

  always_comb begin
    fpc_d      = fpc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (bus.redirect) begin
      // A redirect wins over everything, including this cycle's response and pop.
      fpc_d    = bus.redirect_pc & ~32'd3;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        req_pc_d = fpc_q;
        fpc_d    = fpc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q      <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fpc_q      <= fpc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue payload needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= bus.im_rdata;
    end
  end

  always_comb begin
    bus.im_req    = issue;
    bus.im_addr   = fpc_q[IM_AW-1:0];
    bus.out_valid = head_valid;
    bus.out_pc    = pc_mem[rd_ptr_q];
    bus.out_instr = instr_mem[rd_ptr_q];
    bus.out_npc   = pc_mem[rd_ptr_q] + 32'd4;
    bus.fq_count  = count_q;
  end

  assign dbg_fpc_o      = fpc_q;
  assign dbg_inflight_o = inflight_q;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: a PC-stream reference model drives an expected
// queue of fetched-but-unconsumed PCs, plus directed scenario checks.
module tb_ifu_fetch_queue;
  logic clk;
  logic reset;
  logic [31:0] dbg_fpc;
  logic        dbg_inflight;

  ifu_fetch_queue_if #(.IM_AW(10), .FQ_DEPTH(4)) bus ();

  ifu_fetch_queue #(.RESET_PC(32'h0000_3000), .IM_AW(10), .FQ_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dbg_fpc_o      (dbg_fpc),
    .dbg_inflight_o (dbg_inflight)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {12'hA5C, a, a};
  endfunction

  always @(posedge clk) bus.im_rdata <= mem_word(bus.im_addr);

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] fetch_pc;
  bit          last_issue;
  int          total;
  int          bad;
  int          n_pops;
  bit          first_seen;
  logic [31:0] first_pop;
  logic        s_valid, s_req;
  logic [31:0] s_pc, s_npc;
  logic [9:0]  s_addr;
  logic [2:0]  s_count;

  function automatic void model_clear();
    exp_q.delete();
    fetch_pc   = 32'h0000_3000;
    last_issue = 1'b0;
    n_pops     = 0;
    first_seen = 1'b0;
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, advance the model.
  task automatic tick(input bit rd, input bit rdr, input logic [31:0] rpc);
    int occ;
    bit exp_valid, exp_req;
    logic [31:0] hp;
    @(negedge clk);
    bus.out_ready   = rd;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
    #1;
    s_valid = bus.out_valid; s_req = bus.im_req; s_pc = bus.out_pc;
    s_npc = bus.out_npc; s_addr = bus.im_addr; s_count = bus.fq_count;
    occ = exp_q.size() - int'(last_issue);
    exp_valid = (occ > 0);
    exp_req = !rdr && (exp_q.size() < 4);
    total++;
    if (s_count !== 3'(occ)) begin
      bad++; $display("FAIL fq_count: got %0d want %0d", s_count, occ);
    end
    total++;
    if (s_valid !== exp_valid) begin
      bad++; $display("FAIL out_valid: got %b want %b", s_valid, exp_valid);
    end
    total++;
    if (s_req !== exp_req) begin
      bad++; $display("FAIL im_req: got %b want %b", s_req, exp_req);
    end
    if (exp_valid) begin
      hp = exp_q[0];
      total++;
      if (s_pc !== hp) begin
        bad++; $display("FAIL out_pc: got %h want %h", s_pc, hp);
      end
      total++;
      if (bus.out_instr !== mem_word(hp[9:0])) begin
        bad++; $display("FAIL out_instr: got %h want %h", bus.out_instr, mem_word(hp[9:0]));
      end
      total++;
      if (s_npc !== hp + 32'd4) begin
        bad++; $display("FAIL out_npc: got %h want %h", s_npc, hp + 32'd4);
      end
    end
    if (exp_req) begin
      total++;
      if (s_addr !== fetch_pc[9:0]) begin
        bad++; $display("FAIL im_addr: got %h want %h", s_addr, fetch_pc[9:0]);
      end
    end
    if (rdr) begin
      exp_q.delete();
      fetch_pc   = rpc & ~32'd3;
      last_issue = 1'b0;
    end else begin
      if (exp_valid && rd) begin
        hp = exp_q.pop_front();
        n_pops++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_pop  = hp;
        end
      end
      if (exp_req) begin
        exp_q.push_back(fetch_pc);
        fetch_pc = fetch_pc + 32'd4;
      end
      last_issue = exp_req;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; bus.out_ready = 1'b0; bus.redirect = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.out_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    model_clear();
    #3;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    total++;
    if (bus.im_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.im_req); end
    total++;
    if (bus.fq_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.fq_count); end
    total++;
    if (dbg_fpc !== 32'h0000_3000) begin bad++; $display("FAIL reset_fpc: got %h want 00003000", dbg_fpc); end
    total++;
    if (dbg_inflight !== 1'b0) begin bad++; $display("FAIL reset_inflight: got %b want 0", dbg_inflight); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_stream();
    int first_v;
    pulse_reset();
    first_v = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, '0);
      if (s_valid && first_v < 0) first_v = i;
    end
    total++;
    if (first_v != 2) begin bad++; $display("FAIL stream_latency: got %0d want 2", first_v); end
    total++;
    if (first_pop !== 32'h0000_3000) begin bad++; $display("FAIL stream_first: got %h want 00003000", first_pop); end
    total++;
    if (n_pops != 18) begin bad++; $display("FAIL stream_rate: got %0d want 18", n_pops); end
  endtask

  task automatic test_stall();
    pulse_reset();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0);
    total++;
    if (s_count !== 3'd4) begin bad++; $display("FAIL stall_count: got %0d want 4", s_count); end
    total++;
    if (s_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", s_req); end
    total++;
    if (dbg_fpc !== 32'h0000_3010) begin bad++; $display("FAIL stall_fpc: got %h want 00003010", dbg_fpc); end
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, '0);
    total++;
    if (first_pop !== 32'h0000_3000) begin bad++; $display("FAIL stall_first: got %h want 00003000", first_pop); end
  endtask

  task automatic test_redirect_flush();
    pulse_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 32'h0000_3040);
    total++;
    if (s_count !== 3'd3 || dbg_inflight !== 1'b1) begin
      bad++; $display("FAIL flush_pre: got count=%0d inflight=%b want 3/1", s_count, dbg_inflight);
    end
    tick(1'b1, 1'b0, '0);
    total++;
    if (s_count !== 3'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", s_count); end
    tick(1'b1, 1'b0, '0);
    total++;
    if (s_valid !== 1'b0) begin bad++; $display("FAIL flush_gap: got %b want 0", s_valid); end
    tick(1'b1, 1'b0, '0);
    total++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0000_3040) begin
      bad++; $display("FAIL flush_target: got v=%b pc=%h want 1/00003040", s_valid, s_pc);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, '0);
  endtask

  task automatic test_misaligned_b2b();
    pulse_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 32'h0000_3042);
    tick(1'b1, 1'b0, '0);
    total++;
    if (s_req !== 1'b1 || s_addr !== 10'h040) begin
      bad++; $display("FAIL misalign_addr: got req=%b addr=%h want 1/040", s_req, s_addr);
    end
    tick(1'b1, 1'b1, 32'h0000_3100);
    tick(1'b1, 1'b1, 32'h0000_3200);
    first_seen = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, '0);
    total++;
    if (first_pop !== 32'h0000_3200) begin bad++; $display("FAIL b2b_first: got %h want 00003200", first_pop); end
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    total++;
    if (s_pc !== 32'hFFFF_FFFC || s_npc !== 32'h0000_0000) begin
      bad++; $display("FAIL npc_wrap: got pc=%h npc=%h want fffffffc/00000000", s_pc, s_npc);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i < 40; i++) tick(i[0] == 1'b0, 1'b0, '0);
    total++;
    if (n_pops < 18) begin bad++; $display("FAIL toggle_pops: got %0d want >=18", n_pops); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, '0);
  endtask

  task automatic test_async_reset();
    pulse_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, '0);
    @(negedge clk);
    bus.out_ready = 1'b1; bus.redirect = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre: got %b want 1", bus.out_valid); end
    reset = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.im_req !== 1'b0 || bus.fq_count !== 3'd0) begin
      bad++; $display("FAIL areset_clear: got v=%b req=%b cnt=%0d want 0/0/0",
                      bus.out_valid, bus.im_req, bus.fq_count);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== 10'h000) begin
      bad++; $display("FAIL areset_restart: got req=%b addr=%h want 1/000", bus.im_req, bus.im_addr);
    end
    model_clear();
    exp_q.push_back(32'h0000_3000);
    fetch_pc   = 32'h0000_3004;
    last_issue = 1'b1;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, '0);
    total++;
    if (first_pop !== 32'h0000_3000) begin bad++; $display("FAIL areset_first: got %h want 00003000", first_pop); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_misaligned_b2b();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
